// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The boot image below is only written when INSTR_MEM_BOOT_PROG_EN is defined.
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam int BOOT_LEN = 5;

  // ADDI $1,$0,0xCA followed by four ADD $1,$1,$1
  localparam logic [31:0] BOOT_PROG [BOOT_LEN] = '{
    32'h2001_00CA,
    32'h0021_0820,
    32'h0021_0820,
    32'h0021_0820,
    32'h0021_0820
  };

  function automatic logic [31:0] boot_word(input int idx);
    if (idx >= 0 && idx < BOOT_LEN) begin
      return BOOT_PROG[idx[2:0]];
    end
    return NOP_INSTR;
  endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load signals of the instruction memory.
// master = PC/loader side, slave = memory side.
interface instr_mem_loadable_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 6
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           RD;
  logic                  rd_valid;
  logic                  addr_oob;
  logic                  load_en;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_full;
  logic [LEN_WIDTH-1:0]  prog_len;

  modport master (
    output fetch_req, address, load_en, load_valid, load_byte,
    input  RD, rd_valid, addr_oob, load_full, prog_len
  );

  modport slave (
    input  fetch_req, address, load_en, load_valid, load_byte,
    output RD, rd_valid, addr_oob, load_full, prog_len
  );
endinterface

// File: rtl/instr_mem_loadable_byte_word_packer.sv
// Assembles four serial bytes (first byte = bits 31:24) into one 32-bit word.
// word/word_valid are combinational on the 4th byte so the write lands on that edge.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  count_reg;
  logic [23:0] shift_reg;

  assign word_valid = byte_valid && (count_reg == 2'd3);
  assign word       = {shift_reg, byte_in};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= 2'd0;
      shift_reg <= 24'h0;
    end else if (byte_valid) begin
      count_reg <= count_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_in};
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Word-indexed instruction memory with registered fetch and a byte-serial load port.
// Optional: INSTR_MEM_BOOT_PROG_EN makes reset write a built-in boot program.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loadable_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INSTR_MEM_BOOT_PROG_EN
  localparam logic [LEN_WIDTH-1:0] RESET_LEN = LEN_WIDTH'(BOOT_LEN);
`else
  localparam logic [LEN_WIDTH-1:0] RESET_LEN = '0;
`endif

  state_t               state_reg, state_next;
  logic                 load_entry, load_exit;
  logic [LEN_WIDTH-1:0] wr_ptr_reg, prog_len_reg;
  logic                 load_full_reg;
  logic                 byte_accept, word_valid;
  logic [31:0]          word;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 fetch_ok, fetch_oob;
  logic [31:0]          rd_reg;
  logic                 rd_valid_reg, addr_oob_reg;
  logic [31:0]          mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_entry = 1'b0;
    load_exit  = 1'b0;
    case (state_reg)
      RUN: if (bus.load_en) begin
        state_next = LOAD;
        load_entry = 1'b1;
      end
      LOAD: if (!bus.load_en) begin
        state_next = RUN;
        load_exit  = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // Bytes arriving on the exit cycle or after the memory is full are dropped.
  assign byte_accept = !reset && (state_reg == LOAD) && bus.load_en
                       && bus.load_valid && !load_full_reg;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_entry || load_exit),
    .byte_valid (byte_accept),
    .byte_in    (bus.load_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      prog_len_reg  <= RESET_LEN;
      load_full_reg <= 1'b0;
    end else if (load_entry) begin
      wr_ptr_reg    <= '0;
      prog_len_reg  <= '0;
      load_full_reg <= 1'b0;
    end else if (word_valid) begin
      wr_ptr_reg   <= wr_ptr_reg + 1'b1;
      prog_len_reg <= prog_len_reg + 1'b1;
      if (wr_ptr_reg == LEN_WIDTH'(DEPTH - 1)) load_full_reg <= 1'b1;
    end
  end

  assign wr_idx = wr_ptr_reg[IDX_W-1:0];

`ifdef INSTR_MEM_BOOT_PROG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= boot_word(i);
    end else if (word_valid) begin
      mem[wr_idx] <= word;
    end
  end
`else
  // No reset on the array so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (word_valid) mem[wr_idx] <= word;
  end
`endif

  // Fetches are only honoured in RUN with load_en low, so load entry wins.
  assign fetch_ok  = (state_reg == RUN) && !bus.load_en && bus.fetch_req;
  assign fetch_oob = 32'(bus.address) >= 32'(DEPTH);
  assign rd_idx    = bus.address[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_reg       <= NOP_INSTR;
      rd_valid_reg <= 1'b0;
      addr_oob_reg <= 1'b0;
    end else begin
      rd_valid_reg <= fetch_ok;
      addr_oob_reg <= fetch_ok && fetch_oob;
      if (fetch_ok) rd_reg <= fetch_oob ? NOP_INSTR : mem[rd_idx];
    end
  end

  assign bus.RD        = rd_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.addr_oob  = addr_oob_reg;
  assign bus.load_full = load_full_reg;
  assign bus.prog_len  = prog_len_reg;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: a 32-word instance and a 4-word instance.
// Fetch expectations are queued at issue; negedge monitors pop and compare on rd_valid.
module tb_instr_mem_loadable;

  localparam int AW  = 8;
  localparam int LW  = 6;
  localparam int LW4 = 3;

  typedef struct {
    logic [31:0] data;
    logic        oob;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q4[$];

`ifdef INSTR_MEM_BOOT_PROG_EN
  localparam logic [31:0] RESET_LEN = 32'd5;
`else
  localparam logic [31:0] RESET_LEN = 32'd0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_loadable_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW))  bus ();
  instr_mem_loadable_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW4)) bus4 ();

  instr_mem_loadable #(.ADDR_WIDTH(AW), .DEPTH(32), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instr_mem_loadable #(.ADDR_WIDTH(AW), .DEPTH(4), .LEN_WIDTH(LW4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL fetch32 unexpected rd_valid RD=%h cyc=%0d", bus.RD, cyc);
      end else begin
        e = q0.pop_front();
        if (bus.RD !== e.data || bus.addr_oob !== e.oob || cyc != e.cyc) begin
          errors++;
          $display("FAIL fetch32 got RD=%h oob=%b cyc=%0d want RD=%h oob=%b cyc=%0d",
                   bus.RD, bus.addr_oob, cyc, e.data, e.oob, e.cyc);
        end else begin
          $display("fetch32 RD=%h oob=%b cyc=%0d ok", bus.RD, bus.addr_oob, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus4.rd_valid === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL fetch4 unexpected rd_valid RD=%h cyc=%0d", bus4.RD, cyc);
      end else begin
        e = q4.pop_front();
        if (bus4.RD !== e.data || bus4.addr_oob !== e.oob || cyc != e.cyc) begin
          errors++;
          $display("FAIL fetch4 got RD=%h oob=%b cyc=%0d want RD=%h oob=%b cyc=%0d",
                   bus4.RD, bus4.addr_oob, cyc, e.data, e.oob, e.cyc);
        end else begin
          $display("fetch4 RD=%h oob=%b cyc=%0d ok", bus4.RD, bus4.addr_oob, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // Called just after a negedge; the result shows at the following negedge.
  task automatic fetch(input bit w, input int a, input logic [31:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.oob  = o;
    e.cyc  = cyc + 1;
    if (w) begin
      bus4.fetch_req = 1'b1;
      bus4.address   = AW'(a);
      q4.push_back(e);
    end else begin
      bus.fetch_req = 1'b1;
      bus.address   = AW'(a);
      q0.push_back(e);
    end
    @(negedge clk);
    if (w) bus4.fetch_req = 1'b0;
    else   bus.fetch_req  = 1'b0;
  endtask

  task automatic send_byte(input bit w, input logic [7:0] b);
    if (w) begin
      bus4.load_valid = 1'b1;
      bus4.load_byte  = b;
    end else begin
      bus.load_valid = 1'b1;
      bus.load_byte  = b;
    end
    @(negedge clk);
    if (w) bus4.load_valid = 1'b0;
    else   bus.load_valid  = 1'b0;
  endtask

  task automatic send_word(input bit w, input logic [31:0] word);
    logic [31:0] tmp;
    tmp = word;
    for (int i = 0; i < 4; i++) begin
      send_byte(w, tmp[31:24]);
      tmp = tmp << 8;
    end
  endtask

  task automatic set_len(input bit w, input logic v);
    if (w) bus4.load_en = v;
    else   bus.load_en  = v;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.fetch_req  = 1'b0; bus.address  = '0; bus.load_en  = 1'b0;
    bus.load_valid = 1'b0; bus.load_byte = '0;
    bus4.fetch_req  = 1'b0; bus4.address  = '0; bus4.load_en  = 1'b0;
    bus4.load_valid = 1'b0; bus4.load_byte = '0;
    repeat (2) @(negedge clk);

    chk("reset_RD", bus.RD, 32'h0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset_addr_oob", 32'(bus.addr_oob), 32'h0);
    chk("reset_load_full", 32'(bus.load_full), 32'h0);
    chk("reset_prog_len", 32'(bus.prog_len), RESET_LEN);
    chk("reset_load_full4", 32'(bus4.load_full), 32'h0);
    reset = 1'b0;
    @(negedge clk);

`ifdef INSTR_MEM_BOOT_PROG_EN
    fetch(0, 0, 32'h2001_00CA, 1'b0);
    for (int i = 1; i <= 4; i++) fetch(0, i, 32'h0021_0820, 1'b0);
    fetch(0, 5, 32'h0000_0000, 1'b0);
    @(negedge clk);
`endif

    // load two words, then fetch them back to back
    set_len(0, 1'b1);
    send_word(0, 32'h2001_00CA);
    send_word(0, 32'h0021_0820);
    set_len(0, 1'b0);
    chk("load2_prog_len", 32'(bus.prog_len), 32'd2);
    fetch(0, 0, 32'h2001_00CA, 1'b0);
    fetch(0, 1, 32'h0021_0820, 1'b0);

    // single fetch then RD must hold while idle
    fetch(0, 1, 32'h0021_0820, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("idle_RD_hold", bus.RD, 32'h0021_0820);
    end

    // out-of-range fetches, including the first index past the end
    fetch(0, 40, 32'h0, 1'b1);
    fetch(0, 32, 32'h0, 1'b1);
    @(negedge clk);
    chk("oob_cleared", 32'(bus.addr_oob), 32'h0);

    // load entry with fetch_req high: fetch ignored on entry and in LOAD
    bus.load_en   = 1'b1;
    bus.fetch_req = 1'b1;
    bus.address   = '0;
    @(negedge clk);
    chk("entry_fetch_ignored", 32'(bus.rd_valid), 32'h0);
    chk("entry_prog_len_clr", 32'(bus.prog_len), 32'd0);
    @(negedge clk);
    chk("load_fetch_ignored", 32'(bus.rd_valid), 32'h0);
    bus.fetch_req = 1'b0;

    // one full word then a 2-byte partial that must be dropped
    send_word(0, 32'hDEAD_BEEF);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    set_len(0, 1'b0);
    chk("partial_prog_len", 32'(bus.prog_len), 32'd1);
    fetch(0, 0, 32'hDEAD_BEEF, 1'b0);
    fetch(0, 1, 32'h0021_0820, 1'b0);

    // 4th byte arriving on the exit cycle is ignored
    set_len(0, 1'b1);
    send_byte(0, 8'h55);
    send_byte(0, 8'h66);
    send_byte(0, 8'h77);
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'h88;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("exit4th_prog_len", 32'(bus.prog_len), 32'd0);
    fetch(0, 0, 32'hDEAD_BEEF, 1'b0);

    // reset in the middle of a word
    set_len(0, 1'b1);
    send_word(0, 32'h0102_0304);
    send_byte(0, 8'hA1);
    send_byte(0, 8'hA2);
    chk("midload_prog_len", 32'(bus.prog_len), 32'd1);
    reset       = 1'b1;
    bus.load_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_midload_prog_len", 32'(bus.prog_len), RESET_LEN);
`ifdef INSTR_MEM_BOOT_PROG_EN
    fetch(0, 0, 32'h2001_00CA, 1'b0);
`else
    fetch(0, 0, 32'h0102_0304, 1'b0);
`endif

    // full condition on the 4-word instance
    set_len(1, 1'b1);
    for (int i = 0; i < 3; i++) send_word(1, 32'hAABB_CCDD);
    chk("full4_before", 32'(bus4.load_full), 32'h0);
    send_word(1, 32'hAABB_CCDD);
    chk("full4_set", 32'(bus4.load_full), 32'h1);
    chk("full4_prog_len", 32'(bus4.prog_len), 32'd4);
    send_word(1, 32'h1122_3344);
    chk("full4_extra_prog_len", 32'(bus4.prog_len), 32'd4);
    set_len(1, 1'b0);
    chk("full4_hold", 32'(bus4.load_full), 32'h1);
    fetch(1, 0, 32'hAABB_CCDD, 1'b0);
    fetch(1, 3, 32'hAABB_CCDD, 1'b0);
    fetch(1, 4, 32'h0, 1'b1);

    repeat (3) @(negedge clk);
    chk("q32_drained", 32'(q0.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised successor to the CPU's fixed instruction ROM.
- Synchronous-read, word-indexed instruction memory. Fetch has a 1-cycle valid-pulse handshake.
- A byte-serial program-load port writes the program at run time, so no RTL edit is needed to change it.
- Sits between the PC register and the decoder of the single-cycle MIPS core.

Parameters:
- ADDR_WIDTH, 8, width of the fetch word index.
- DEPTH, 32, number of 32-bit words stored; must be ≤ 2**ADDR_WIDTH.
- LEN_WIDTH, $clog2(DEPTH+1), width of the prog_len counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_req  input  1  fetch request, sampled on the clk edge.
- address  input  ADDR_WIDTH  word index to fetch.
- RD  output  32  fetched instruction word.
- rd_valid  output  1  1-cycle pulse; RD is valid for this request.
- addr_oob  output  1  qualifies rd_valid; the fetched index was ≥ DEPTH.
- load_en  input  1  level; 1 = LOAD mode, 0 = RUN mode.
- load_valid  input  1  load_byte is valid this cycle.
- load_byte  input  8  program byte, MSB-first within each word.
- load_full  output  1  DEPTH words written during the current LOAD session.
- prog_len  output  LEN_WIDTH  words written since the last LOAD entry or reset.

Behaviour:
- Reset values:
  - RD=32'h0000_0000; rd_valid, addr_oob, load_full = 0; prog_len=0.
  - FSM=RUN; write pointer and byte counter = 0.
  - Memory array is not cleared (see Optional Feature).
- FSM states:
  - RUN → LOAD when load_en=1. Write pointer, byte counter, prog_len and load_full are cleared on the entry cycle.
  - LOAD → RUN when load_en=0. A partial word (1–3 bytes) is discarded and memory is unchanged.
- RUN fetch:
  - fetch_req=1 at edge n gives RD=mem[address] and rd_valid=1 at edge n+1 (latency 1).
  - No request: rd_valid=0 and RD holds its last value.
  - Back-to-back requests give back-to-back results.
- Out-of-range fetch (address ≥ DEPTH): RD=32'h0000_0000 (NOP), rd_valid=1 and addr_oob=1 in the same cycle.
- LOAD mode:
  - fetch_req is ignored and rd_valid stays 0.
  - On the entry cycle, fetch_req is also ignored (load has priority).
  - Each load_valid byte shifts into a 32-bit assembly register, first byte → bits 31:24.
  - On the 4th byte: the word is written to mem[wr_ptr] at that edge, wr_ptr++, prog_len++, byte counter returns to 0.
- Full condition:
  - When wr_ptr reaches DEPTH, load_full=1.
  - Further bytes are ignored (no wrap, no overwrite).
  - load_full holds until the next LOAD entry or reset.
- Read/write collision: the write completes in LOAD and reads occur only in RUN, so no same-address hazard exists.
- Reset mid-load: the partial word is discarded, completed words stay in memory, FSM=RUN, prog_len=0.
- load_en deasserted on the same cycle as a 4th byte: the byte is ignored and the partial word is dropped (state exit has priority).

Optional Feature:
- Macro: INSTR_MEM_BOOT_PROG_EN.
- Defined: reset also writes the built-in boot program and sets prog_len=5.
  - mem[0]=32'h200100CA (ADDI $1,$0,0xCA)
  - mem[1..4]=32'h00210820 (ADD $1,$1,$1)
  - All other words = 0.
- Undefined: memory is untouched by reset and prog_len resets to 0.

Decomposition:
- Package instr_mem_pkg:
  - NOP_INSTR constant (32'h0).
  - State enum {RUN, LOAD}.
  - BOOT_PROG localparam array of 5 words and BOOT_LEN=5.
- Sub-module byte_word_packer: byte counter plus shift register. Outputs word_valid and word; cleared by reset or LOAD entry/exit.
- Top holds the FSM, write pointer, memory array and fetch register.

Test Plan:
- Load and fetch back:
  - Stimulus: reset; load_en=1; send bytes 20 01 00 CA 00 21 08 20; load_en=0; fetch idx 0 then 1 on consecutive cycles.
  - Required: RD=200100CA then 00210820, rd_valid pulses on edges n+1 and n+2, prog_len=2.
- Latency and hold:
  - Stimulus: single fetch idx 1, then 3 idle cycles.
  - Required: rd_valid high exactly 1 cycle; RD stays 00210820 through the idle cycles.
- Out-of-range:
  - Stimulus: DEPTH=32, fetch idx 40.
  - Required: RD=00000000, rd_valid=1, addr_oob=1.
- Full condition:
  - Stimulus: DEPTH=4; load 4 words of AABBCCDD, then 4 more bytes 11 22 33 44.
  - Required: load_full=1, prog_len=4, mem[0] still AABBCCDD.
- Partial word and reset mid-load:
  - Stimulus: load 1 word, send 2 bytes, drop load_en, fetch idx 1 (pre-cleared).
  - Required: idx 1 unchanged.
  - Stimulus: a separate reset asserted mid-word.
  - Required: prog_len=0, FSM in RUN, fetch works on the next cycle.
- Boot program (INSTR_MEM_BOOT_PROG_EN defined):
  - Stimulus: reset, then fetch idx 0..5.
  - Required: 200100CA, 00210820 ×4, 00000000; prog_len=5.
